// File: rtl/parallel_ch_link.sv
// parallel_ch_link: host parallel byte link into the CLK_50 domain.
// The host strobes command and data bytes. A command either starts a
// multi-byte read of one sensor channel (LSB first) or a multi-byte
// control-word write. All host pins are asynchronous and are synchronised
// before use.
module parallel_ch_link #(
    parameter int BUS_W      = 8,
    parameter int CH_NUM     = 3,
    parameter int WORD_BYTES = 2,
    parameter int CMD_BASE   = 120,
    parameter int CMD_WR     = 119
) (
    input  logic                                CLK_50,
    input  logic                                iRSTN,
    input  logic                                RP_clock,
    input  logic                                RP_CS,
    input  logic [BUS_W-1:0]                    RP_data_i,
    output logic [BUS_W-1:0]                    RP_data_o,
    output logic                                RP_data_oe,
    input  logic [CH_NUM*WORD_BYTES*BUS_W-1:0]  ch_data,
    output logic [WORD_BYTES*BUS_W-1:0]         ctrl_word,
    output logic                                ctrl_stb,
    output logic                                cmd_err,
    output logic                                busy
);

    localparam int WORD_W = WORD_BYTES * BUS_W;
    localparam int CNT_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WORD_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_TX   = 2'd2,
        ST_RX   = 2'd3
    } state_t;

    // Synchroniser flops
    logic [2:0]       clk_sync_r;
    logic [1:0]       cs_sync_r;
    logic [BUS_W-1:0] data_meta_r;
    logic [BUS_W-1:0] data_sync_r;

    // Synchronised views of the host pins
    logic             rise_s;
    logic             cs_n_s;
    logic [BUS_W-1:0] byte_s;
    logic [31:0]      cmd_val_s;

    // Command decode
    logic              ch_hit_s;
    logic              wr_hit_s;
    logic [WORD_W-1:0] ch_word_s;

    // Transfer state
    state_t            state_r;
    state_t            state_nx_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nx_s;
    logic [WORD_W-1:0] shadow_r;
    logic [WORD_W-1:0] shadow_nx_s;
    logic [WORD_W-1:0] shadow_shift_s;
    logic [WORD_W-1:0] shift_r;
    logic [WORD_W-1:0] shift_nx_s;
    logic [WORD_W-1:0] rx_word_s;

    // Next values of the registered outputs
    logic [BUS_W-1:0]  data_o_nx_s;
    logic              oe_nx_s;
    logic [WORD_W-1:0] ctrl_word_nx_s;
    logic              ctrl_stb_nx_s;
    logic              cmd_err_nx_s;
    logic              busy_nx_s;

    // Two-flop synchronisers; a third strobe flop forms the rise detector
    always_ff @(posedge CLK_50 or negedge iRSTN) begin
        if (!iRSTN) begin
            clk_sync_r  <= 3'b000;
            cs_sync_r   <= 2'b11;
            data_meta_r <= '0;
            data_sync_r <= '0;
        end else begin
            clk_sync_r  <= {clk_sync_r[1:0], RP_clock};
            cs_sync_r   <= {cs_sync_r[0], RP_CS};
            data_meta_r <= RP_data_i;
            data_sync_r <= data_meta_r;
        end
    end

    assign rise_s    = clk_sync_r[1] & ~clk_sync_r[2];
    assign cs_n_s    = cs_sync_r[1];
    assign byte_s    = data_sync_r;
    assign cmd_val_s = 32'(byte_s);
    assign wr_hit_s  = (cmd_val_s == 32'(CMD_WR));

    // Channel command decode and selection of the addressed channel word
    always_comb begin
        ch_hit_s  = 1'b0;
        ch_word_s = '0;
        for (int n = 0; n < CH_NUM; n++) begin
            if (cmd_val_s == 32'(CMD_BASE + n)) begin
                ch_hit_s  = 1'b1;
                ch_word_s = ch_data[n*WORD_W +: WORD_W];
            end else begin
                ch_hit_s  = ch_hit_s;
                ch_word_s = ch_word_s;
            end
        end
    end

    // Next byte of the read shadow, and the write word with the new byte on top
    always_comb begin
        shadow_shift_s = shadow_r >> BUS_W;
        rx_word_s      = shift_r >> BUS_W;
        rx_word_s[WORD_W-1 -: BUS_W] = byte_s;
    end

    // Next-state and registered-output decode; a deasserted CS overrides everything
    always_comb begin
        state_nx_s     = state_r;
        cnt_nx_s       = cnt_r;
        shadow_nx_s    = shadow_r;
        shift_nx_s     = shift_r;
        data_o_nx_s    = RP_data_o;
        oe_nx_s        = RP_data_oe;
        ctrl_word_nx_s = ctrl_word;
        ctrl_stb_nx_s  = 1'b0;
        cmd_err_nx_s   = 1'b0;
        if (cs_n_s) begin
            state_nx_s = ST_IDLE;
            oe_nx_s    = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nx_s = ST_CMD;
                end
                ST_CMD: begin
                    if (!rise_s) begin
                        state_nx_s = ST_CMD;
                    end else if (ch_hit_s) begin
                        shadow_nx_s = ch_word_s;
                        data_o_nx_s = ch_word_s[BUS_W-1:0];
                        oe_nx_s     = 1'b1;
                        cnt_nx_s    = '0;
                        state_nx_s  = ST_TX;
                    end else if (wr_hit_s) begin
                        shift_nx_s = '0;
                        cnt_nx_s   = '0;
                        state_nx_s = ST_RX;
                    end else begin
                        cmd_err_nx_s = 1'b1;
                    end
                end
                ST_TX: begin
                    if (!rise_s) begin
                        state_nx_s = ST_TX;
                    end else if (cnt_r == LAST_BEAT) begin
                        // This acknowledge ends the word; it is not a command
                        oe_nx_s    = 1'b0;
                        state_nx_s = ST_CMD;
                    end else begin
                        cnt_nx_s    = cnt_r + CNT_W'(1);
                        shadow_nx_s = shadow_shift_s;
                        data_o_nx_s = shadow_shift_s[BUS_W-1:0];
                    end
                end
                ST_RX: begin
                    if (!rise_s) begin
                        state_nx_s = ST_RX;
                    end else if (cnt_r == LAST_BEAT) begin
                        shift_nx_s     = rx_word_s;
                        ctrl_word_nx_s = rx_word_s;
                        ctrl_stb_nx_s  = 1'b1;
                        state_nx_s     = ST_CMD;
                    end else begin
                        shift_nx_s = rx_word_s;
                        cnt_nx_s   = cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_nx_s = ST_IDLE;
                    oe_nx_s    = 1'b0;
                end
            endcase
        end
        busy_nx_s = (state_nx_s == ST_TX) || (state_nx_s == ST_RX);
    end

    // State, transfer registers and registered outputs
    always_ff @(posedge CLK_50 or negedge iRSTN) begin
        if (!iRSTN) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            shadow_r   <= '0;
            shift_r    <= '0;
            RP_data_o  <= '0;
            RP_data_oe <= 1'b0;
            ctrl_word  <= '0;
            ctrl_stb   <= 1'b0;
            cmd_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            cnt_r      <= cnt_nx_s;
            shadow_r   <= shadow_nx_s;
            shift_r    <= shift_nx_s;
            RP_data_o  <= data_o_nx_s;
            RP_data_oe <= oe_nx_s;
            ctrl_word  <= ctrl_word_nx_s;
            ctrl_stb   <= ctrl_stb_nx_s;
            cmd_err    <= cmd_err_nx_s;
            busy       <= busy_nx_s;
        end
    end

endmodule

// File: doc/parallel_ch_link.md
Name: parallel_ch_link

Overview:
- Parametrised successor of the Raspberry Pi parallel byte link. A host (Pi) drives a strobe clock, an active-low chip select and a bidirectional byte bus.
- All pins are synchronised into the CLK_50 domain. A command byte selects one of CH_NUM sensor channels (e.g. accelerometer X/Y/Z) for a multi-byte read, or starts a multi-byte control-word write.
- Sits between the top-level RP_* pins and the sensor/config blocks, replacing the fixed 3-axis, 2-byte read sequencer.

Parameters:
- BUS_W, 8, width of host data bus.
- CH_NUM, 3, number of readable channels.
- WORD_BYTES, 2, bus beats per channel word / control word.
- CMD_BASE, 120, command value for channel 0; channel n uses CMD_BASE+n.
- CMD_WR, 119, command value that starts a control-word write.

Ports:
- CLK_50  in  1  system clock.
- iRSTN  in  1  asynchronous active-low reset.
- RP_clock  in  1  host strobe, asynchronous; rising edge = one bus beat.
- RP_CS  in  1  host chip select, active low, asynchronous.
- RP_data_i  in  BUS_W  host bus input (pad side of inout).
- RP_data_o  out  BUS_W  byte driven to host.
- RP_data_oe  out  1  bus drive enable; top level tri-states RP_data when low.
- ch_data  in  CH_NUM*WORD_BYTES*BUS_W  channel words; channel n occupies bits [(n+1)*WORD_BYTES*BUS_W-1 : n*WORD_BYTES*BUS_W].
- ctrl_word  out  WORD_BYTES*BUS_W  last complete control word written by host.
- ctrl_stb  out  1  one-cycle pulse when ctrl_word updates.
- cmd_err  out  1  one-cycle pulse on an unrecognised command.
- busy  out  1  high while in TX or RX.

Behaviour:
- Reset (iRSTN low, asynchronous): state IDLE, RP_data_o=0, RP_data_oe=0, ctrl_word=0, ctrl_stb=0, cmd_err=0, busy=0, all sync flops 0 (RP_CS sync flops 1).
- Synchronisation: RP_clock, RP_CS and RP_data_i each pass through 2 flops. A third flop on RP_clock gives the rise pulse (sync2 & ~sync3).
- Every action occurs on the CLK_50 edge that registers the rise pulse, i.e. the 3rd CLK_50 edge after the pin edge is first sampled.
- The host holds RP_data_i stable for at least 4 CLK_50 cycles around each rising RP_clock.
- States: IDLE, CMD, TX, RX.
  - IDLE: synced CS low -> CMD. Rise pulses are ignored while CS is high.
  - CMD, on rise:
    - Byte in [CMD_BASE, CMD_BASE+CH_NUM-1]: snapshot the full selected channel word into a shadow register; RP_data_o = byte 0 (bits [BUS_W-1:0]); RP_data_oe=1; beat counter=0; -> TX.
    - Byte == CMD_WR: clear shift register, beat counter=0; -> RX.
    - Any other byte: cmd_err pulses one cycle; stay in CMD.
  - TX, on rise (host acknowledges current byte):
    - Counter < WORD_BYTES-1: increment counter; drive next more-significant byte (LSB first).
    - Counter == WORD_BYTES-1: RP_data_oe=0; -> CMD. This acknowledge edge is not decoded as a command.
    - The shadow register isolates the transfer from ch_data changes mid-transfer; no tearing.
  - RX, on rise: latch RP_data_i into byte position [counter]. When the last byte is latched: ctrl_word <= assembled word and ctrl_stb=1 for exactly one cycle on the same edge; -> CMD.
- RP_data_oe is high only in TX.
- busy = (state==TX or RX).
- CS deasserted (synced high) in any state: -> IDLE on the next CLK_50 edge; RP_data_oe=0. A partial RX is discarded: no ctrl_stb, ctrl_word unchanged.
- CS rise and RP_clock rise detected in the same cycle: CS wins; the beat is ignored.
- Reset mid-transfer: immediate return to reset values. ctrl_word resets to 0.
- Legal parameters: CMD_BASE+CH_NUM <= 2^BUS_W; CMD_WR outside the channel range; WORD_BYTES >= 1.

Test Plan:
1. Read channel 1, default parameters, ch_data channel 1 = 0xBEEF: CS low, beat 121 -> RP_data_o=0xEF, oe=1. Beat -> 0xBE. Beat -> oe=0, busy=0.
2. Back-to-back reads on a single CS: cmd 120 then cmd 122 with ch0=0x1234, ch2=0xA5C3 -> bytes 0x34,0x12 then 0xC3,0xA5. ch_data changed after the command beat does not alter the bytes.
3. Control write: cmd 119, beats 0x55, 0xAA -> ctrl_word=0xAA55, single-cycle ctrl_stb, busy low afterwards.
4. Bad command 0x00 -> one cmd_err pulse, oe stays 0. The next beat 120 is accepted as a valid read.
5. Abort: cmd 119, beat 0x11, CS high -> IDLE, no ctrl_stb, ctrl_word unchanged. A new CS cycle works normally.
6. Parameter sweep BUS_W=4, CH_NUM=5, WORD_BYTES=3, CMD_BASE=2, CMD_WR=0: read channel 4 = 0xABC returns 0xC, 0xB, 0xA. Assert iRSTN low mid-TX -> oe=0 on the same edge, all outputs at reset values.
